// File: rtl/fft_pkg.sv
// Shared FFT types and helpers used by radix22_top and the output reorder buffer.
package fft_pkg;

  localparam int unsigned FFT_DATA_WIDTH = 16;
  localparam int unsigned FFT_N_POINTS   = 16;
  localparam int unsigned FFT_LOG2N      = $clog2(FFT_N_POINTS);

  typedef struct packed {
    logic signed [FFT_DATA_WIDTH-1:0] re;
    logic signed [FFT_DATA_WIDTH-1:0] im;
  } cplx_t;

  function automatic int unsigned log2n(input int unsigned n);
    return $clog2(n);
  endfunction

  // Reverse the low 'width' bits of k; shift-based so no variable bit selects.
  function automatic logic [31:0] bitrev(input logic [31:0] k, input int unsigned width);
    logic [31:0] src;
    logic [31:0] res;
    src = k;
    res = '0;
    for (int unsigned i = 0; i < width; i++) begin
      res = (res << 1) | (src & 32'd1);
      src = src >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_pp_bank.sv
// One N-entry complex register bank: synchronous write, asynchronous read.
module fft_pp_bank #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the full flags gate every read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: takes bit-reversed FFT frames, replays them in natural bin order.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = FFT_DATA_WIDTH,
  parameter  int unsigned N_POINTS   = FFT_N_POINTS,
  localparam int unsigned LOG2N      = $clog2(N_POINTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_re,
  input  logic [DATA_WIDTH-1:0] in_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_re,
  output logic [DATA_WIDTH-1:0] out_im,
  output logic [LOG2N-1:0]      out_idx,
  output logic                  out_last
);

  localparam int unsigned      CW   = 2 * DATA_WIDTH;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N_POINTS - 1);

  logic [1:0]       full;
  logic             wsel;
  logic             rsel;
  logic [LOG2N-1:0] wcnt;
  logic [LOG2N-1:0] ridx;

  logic             in_fire;
  logic             out_fire;
  logic             wr_done;
  logic             rd_done;
  logic [1:0]       we;
  logic [1:0]       full_set;
  logic [1:0]       full_clr;
  logic [LOG2N-1:0] waddr;
  logic [CW-1:0]    wdata;
  logic [CW-1:0]    rdata0;
  logic [CW-1:0]    rdata1;
  logic [CW-1:0]    rdata;

  // Handshakes, bank steering and gated read outputs, all from registered state.
  always_comb begin
    in_ready  = rst & en & ~full[wsel];
    in_fire   = in_valid & in_ready;
    out_valid = en & full[rsel];
    out_fire  = out_valid & out_ready;
    wr_done   = in_fire & (wcnt == LAST);
    rd_done   = out_fire & (ridx == LAST);
    waddr     = LOG2N'(bitrev(32'(wcnt), LOG2N));
    wdata     = {in_re, in_im};
    we        = 2'b00;
    full_set  = 2'b00;
    full_clr  = 2'b00;
    if (in_fire) we[wsel]       = 1'b1;
    if (wr_done) full_set[wsel] = 1'b1;
    if (rd_done) full_clr[rsel] = 1'b1;
    rdata     = rsel ? rdata1 : rdata0;
    out_re    = out_valid ? rdata[CW-1:DATA_WIDTH] : '0;
    out_im    = out_valid ? rdata[DATA_WIDTH-1:0]  : '0;
    out_idx   = out_valid ? ridx : '0;
    out_last  = out_valid & (ridx == LAST);
  end

  // Writer and reader never touch the same bank, so set and clear never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 2'b00;
      wsel <= 1'b0;
      rsel <= 1'b0;
      wcnt <= '0;
      ridx <= '0;
    end else begin
      full <= (full | full_set) & ~full_clr;
      if (in_fire) begin
        wcnt <= wcnt + LOG2N'(1);
        if (wr_done) wsel <= ~wsel;
      end
      if (out_fire) begin
        ridx <= ridx + LOG2N'(1);
        if (rd_done) rsel <= ~rsel;
      end
    end
  end

  fft_pp_bank #(.WIDTH(CW), .DEPTH(N_POINTS)) u_bank0 (
    .clk   (clk),
    .we    (we[0]),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (ridx),
    .rdata (rdata0)
  );

  fft_pp_bank #(.WIDTH(CW), .DEPTH(N_POINTS)) u_bank1 (
    .clk   (clk),
    .we    (we[1]),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (ridx),
    .rdata (rdata1)
  );

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder with a frame scoreboard built from a hand-written bitrev table.
module tb_fft_bitrev_reorder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_re;
  logic [15:0] in_im;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_re;
  logic [15:0] out_im;
  logic [3:0]  out_idx;
  logic        out_last;

  fft_bitrev_reorder dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int          bitrev_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  logic [31:0] frame_buf [16];
  logic [31:0] exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          wpos = 0;
  int          exp_idx = 0;
  int          gseq = 0;
  int          n_in = 0;
  int          n_out = 0;
  int          cyc = 0;
  logic        last_ir;
  logic        last_ov;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, sample mid-cycle, score handshakes, advance past the edge.
  task automatic step(input logic iv, input logic ordy);
    logic fi;
    logic fo;
    in_valid  = iv;
    out_ready = ordy;
    in_re     = 16'(gseq);
    in_im     = 16'(32'h100 + 32'(gseq));
    #3;
    last_ir = in_ready;
    last_ov = out_valid;
    fi = in_valid & in_ready;
    fo = out_valid & out_ready;
    if (!rst || !en) begin
      check("idle_in_ready", 32'(in_ready), 32'd0);
      check("idle_out_valid", 32'(out_valid), 32'd0);
    end
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("out_data", {out_re, out_im}, exp_q[0]);
        check("out_idx", 32'(out_idx), 32'(exp_idx));
        check("out_last", 32'(out_last), 32'(exp_idx == 15));
      end
    end else begin
      check("out_zero", {out_re, out_im, 4'(out_idx), 1'(out_last)}, 37'd0);
    end
    if (fo && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      exp_idx = (exp_idx + 1) % 16;
      n_out++;
    end
    if (fi) begin
      frame_buf[wpos] = {in_re, in_im};
      wpos++;
      gseq++;
      n_in++;
      if (wpos == 16) begin
        for (int i = 0; i < 16; i++) exp_q.push_back(frame_buf[bitrev_tab[i]]);
        wpos = 0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Finish any partial input frame, then empty the output side within a bound.
  task automatic drain();
    int guard;
    guard = 0;
    while (wpos != 0 && guard < 200) begin
      step(1'b1, 1'b1);
      guard++;
    end
    while ((exp_q.size() != 0 || out_valid) && guard < 400) begin
      step(1'b0, 1'b1);
      guard++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_count", 32'(n_out), 32'(n_in));
  endtask

  initial begin
    int base;
    int drops;
    int vcnt;
    int first_v;
    int last_v;
    int guard;

    rst = 1'b0;
    en = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_re = '0;
    in_im = '0;
    @(posedge clk);
    #1;

    // Reset state
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("reset_accepts", 32'(n_in), 32'd0);
    rst = 1'b1;

    // Single frame: latency and natural-order replay
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1);
    check("t1_accepts", 32'(n_in), 32'd16);
    step(1'b0, 1'b1);
    check("t1_latency", 32'(last_ov), 32'd1);
    drain();

    // Three back-to-back frames with no bubbles
    base = n_in;
    drops = 0;
    vcnt = 0;
    first_v = -1;
    last_v = -1;
    for (int i = 0; i < 68; i++) begin
      step(i < 48, 1'b1);
      if (i < 48 && !last_ir) drops++;
      if (last_ov) begin
        vcnt++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
    end
    check("t2_in_ready_drops", 32'(drops), 32'd0);
    check("t2_accepts", 32'(n_in - base), 32'd48);
    check("t2_valid_count", 32'(vcnt), 32'd48);
    check("t2_valid_span", 32'(last_v - first_v + 1), 32'd48);
    drain();

    // Backpressure: two frames buffered, writer stalls, frees after bin 15 of frame 0
    base = n_in;
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0);
    check("t3_accepts", 32'(n_in - base), 32'd32);
    step(1'b1, 1'b0);
    check("t3_stall_ready", 32'(last_ir), 32'd0);
    check("t3_held", 32'(n_in - base), 32'd32);
    drops = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1);
      if (!last_ir) drops++;
    end
    check("t3_stall_cycles", 32'(drops), 32'd16);
    step(1'b1, 1'b1);
    check("t3_ready_back", 32'(last_ir), 32'd1);
    drain();

    // Random handshakes over ten frames
    base = n_in;
    guard = 0;
    while (n_in - base < 160 && guard < 3000) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      guard++;
    end
    check("t4_accepts", 32'(n_in - base), 32'd160);
    drain();

    // Enable pauses on the input side and mid-readout
    base = n_in;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    check("t5_pause_in", 32'(n_in - base), 32'd8);
    en = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    base = n_out;
    en = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    check("t5_pause_out", 32'(n_out - base), 32'd0);
    en = 1'b1;
    drain();

    // Reset mid-frame discards the partial frame
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1);
    rst = 1'b0;
    wpos = 0;
    exp_q.delete();
    exp_idx = 0;
    n_out = n_in - 9;
    n_in = n_in - 9;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    rst = 1'b1;
    base = n_in;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1);
    check("t6_accepts", 32'(n_in - base), 32'd16);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
